// File: rtl/wb_crc32.sv
// Wishbone B4 pipelined CRC-32 (IEEE 802.3, reflected) slave: bytes pushed through DATA, result read back.
// Define WB_CRC32_BYTE_PARALLEL_EN to fold one whole byte per cycle instead of one bit per cycle.
module wb_crc32 #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] POLY       = 32'hEDB88320,
  parameter logic [31:0] INIT_VALUE = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [3:0]            sel,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  output logic                  ack,
  output logic                  stall,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_CRC    = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] dat_d;
  logic        ack_d, err_d;
`ifndef WB_CRC32_BYTE_PARALLEL_EN
  logic [2:0]  bit_q, bit_d;
`endif

  logic [1:0]  reg_sel;
  logic        busy;
  logic        ctrl_rd;
  logic        accept;
  logic [1:0]  lane;
  logic [3:0]  mask_next;
  logic        adr_unused;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic d);
    logic fb;
    fb = c[0] ^ d;
    return (c >> 1) ^ (fb ? POLY : 32'h0);
  endfunction

`ifdef WB_CRC32_BYTE_PARALLEL_EN
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = crc_step(r, b[i]);
    end
    return r;
  endfunction
`endif

  // Lowest enabled lane still waiting in the byte queue.
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  assign reg_sel    = adr[3:2];
  assign adr_unused = ^{adr[ADDR_WIDTH-1:4], adr[1:0]};
  assign busy       = (state_q == SHIFT);
  assign ctrl_rd    = (reg_sel == REG_CTRL) && !we;
  // LOAD also stalls so nothing can slip in between a DATA ack and the first shift.
  assign stall      = (state_q != IDLE) && !ctrl_rd;
  assign accept     = cyc && stb && !stall;
  assign lane       = first_lane(mask_q);
  assign mask_next  = mask_q & ~(4'b0001 << lane);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    data_d  = data_q;
    mask_d  = mask_q;
    dat_d   = 32'h0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifndef WB_CRC32_BYTE_PARALLEL_EN
    bit_d   = bit_q;
`endif

    case (state_q)
      LOAD: begin
        state_d = SHIFT;
`ifndef WB_CRC32_BYTE_PARALLEL_EN
        bit_d   = 3'd0;
`endif
      end
      SHIFT: begin
`ifdef WB_CRC32_BYTE_PARALLEL_EN
        crc_d  = crc_byte(crc_q, data_q[{lane, 3'b000} +: 8]);
        mask_d = mask_next;
        if (mask_next == 4'b0000) state_d = IDLE;
`else
        crc_d = crc_step(crc_q, data_q[{lane, bit_q}]);
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          mask_d = mask_next;
          if (mask_next == 4'b0000) state_d = IDLE;
        end
`endif
      end
      default: ;
    endcase

    // Only CTRL reads get through while shifting, so these never collide with the datapath.
    if (accept) begin
      ack_d = 1'b1;
      case (reg_sel)
        REG_CTRL: begin
          if (we) begin
            if (dat_i[0]) crc_d = INIT_VALUE;
          end else begin
            dat_d = {30'h0, busy, 1'b0};
          end
        end
        REG_DATA: begin
          if (we && (sel != 4'b0000)) begin
            data_d  = dat_i;
            mask_d  = sel;
            state_d = LOAD;
          end
        end
        REG_RESULT: begin
          if (we) begin
            ack_d = 1'b0;
            err_d = 1'b1;
          end else begin
            dat_d = crc_q ^ XOR_OUT;
          end
        end
        default: begin
          if (we) crc_d = dat_i;
          else    dat_d = crc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= INIT_VALUE;
      data_q  <= 32'h0;
      mask_q  <= 4'b0000;
      dat_o   <= 32'h0;
      ack     <= 1'b0;
      err     <= 1'b0;
`ifndef WB_CRC32_BYTE_PARALLEL_EN
      bit_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      dat_o   <= dat_d;
      ack     <= ack_d;
      err     <= err_d;
`ifndef WB_CRC32_BYTE_PARALLEL_EN
      bit_q   <= bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_crc32.sv
// Bench for wb_crc32: constant vector table, randomized traffic against a table-driven CRC model,
// and hand sequences for busy timing, stalls, dropped cycles and reset during shifting.
module tb_wb_crc32;

`ifdef WB_CRC32_BYTE_PARALLEL_EN
  localparam int CPB = 1;
`else
  localparam int CPB = 8;
`endif
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] XOR_OUT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_i = 32'h0;
  logic [31:0] dat_o;
  logic        ack, stall, err;

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic [31:0] adr_noise = 32'h0;
  logic [31:0] tbl [256];
  logic [31:0] model_crc;

  wb_crc32 dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
    .adr(adr), .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        w;
    logic [1:0]  r;
    logic [3:0]  s;
    logic [31:0] d;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [31:0] model_bytes(input logic [31:0] c, input logic [3:0] s,
                                              input logic [31:0] d);
    logic [31:0] r;
    logic [7:0]  idx;
    r = c;
    for (int l = 0; l < 4; l++) begin
      if (s[l]) begin
        idx = r[7:0] ^ d[8*l +: 8];
        r   = tbl[idx] ^ (r >> 8);
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction, held through any stall; returns response sampled 1ns after the accepting edge.
  task automatic applyStimulus(input logic w, input logic [1:0] r, input logic [3:0] s,
                               input logic [31:0] d, output logic [31:0] rd, output logic a,
                               output logic e, output int st, output logic sa);
    st  = 0;
    sa  = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = d;
    adr = {adr_noise[31:4], r, adr_noise[1:0]};
    #1;
    while (stall && st < 200) begin
      @(posedge clk); #1;
      if (ack || err) sa = 1'b1;
      st++;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0; adr = 32'h0;
    rd = dat_o; a = ack; e = err;
  endtask

  task automatic predict(input logic w, input logic [1:0] r, input logic [3:0] s,
                         input logic [31:0] d, output logic [33:0] exp, output logic [31:0] m);
    m   = 32'hFFFFFFFF;
    exp = {1'b1, 1'b0, 32'h0};
    case (r)
      2'd0: if (w) begin if (d[0]) model_crc = INIT; m = 32'h0; end else m = ~32'h2;
      2'd1: if (w) begin model_crc = model_bytes(model_crc, s, d); m = 32'h0; end
      2'd2: if (w) exp = {1'b0, 1'b1, 32'h0}; else exp[31:0] = model_crc ^ XOR_OUT;
      default: if (w) begin model_crc = d; m = 32'h0; end else exp[31:0] = model_crc;
    endcase
  endtask

  task automatic doOp(input string name, input logic w, input logic [1:0] r,
                      input logic [3:0] s, input logic [31:0] d);
    logic [33:0] x;
    logic [31:0] m, rd;
    logic        a, e, sa;
    int          st;
    predict(w, r, s, d, x, m);
    applyStimulus(w, r, s, d, rd, a, e, st, sa);
    checkOutput(name, {30'h0, a, e, rd & m}, {30'h0, x[33:32], x[31:0] & m});
  endtask

  // Writes DATA, then polls CTRL back to back; first poll lands in the ack cycle.
  task automatic measure_busy(input logic [3:0] s, input logic [31:0] d,
                              output int ones, output logic [1:0] head);
    logic [33:0] x;
    logic [31:0] m, rd;
    logic        a, e, sa;
    int          st;
    predict(1'b1, 2'd1, s, d, x, m);
    applyStimulus(1'b1, 2'd1, s, d, rd, a, e, st, sa);
    ones = 0;
    head = 2'b00;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b0, 2'd0, 4'hF, 32'h0, rd, a, e, st, sa);
      if (k < 2) head[k] = rd[1];
      if (rd[1]) ones++;
    end
  endtask

  initial begin
    logic [31:0] rd, c;
    logic        a, e, sa, spur;
    int          st, ones;
    logic [1:0]  head;

    for (int i = 0; i < 256; i++) begin
      c = i;
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      tbl[i] = c;
    end

    vecs[0]  = '{1'b0, 2'd3, 4'hF, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[1]  = '{1'b0, 2'd0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 2'd2, 4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 2'd1, 4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b1, 2'd0, 4'hF, 32'h1,        1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 2'd1, 4'hF, 32'h34333231, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 2'd1, 4'hF, 32'h38373635, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 2'd1, 4'h1, 32'h00000039, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 2'd2, 4'hF, 32'h0,        1'b1, 1'b0, 32'hCBF43926};
    vecs[9]  = '{1'b1, 2'd2, 4'hF, 32'h12345678, 1'b0, 1'b1, 32'h00000000};
    vecs[10] = '{1'b0, 2'd2, 4'hF, 32'h0,        1'b1, 1'b0, 32'hCBF43926};
    vecs[11] = '{1'b0, 2'd3, 4'hF, 32'h0,        1'b1, 1'b0, 32'h340BC6D9};
    vecs[12] = '{1'b1, 2'd0, 4'hF, 32'h1,        1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 2'd1, 4'h2, 32'h00003100, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 2'd2, 4'hF, 32'h0,        1'b1, 1'b0, 32'h83DCEFB7};
    vecs[15] = '{1'b1, 2'd1, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 2'd0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[17] = '{1'b1, 2'd3, 4'h0, 32'h00000000, 1'b1, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 2'd3, 4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[19] = '{1'b1, 2'd0, 4'hF, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 2'd3, 4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[21] = '{1'b0, 2'd2, 4'hF, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_outputs", {29'h0, ack, err, stall, dat_o}, 64'h0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].w, vecs[i].r, vecs[i].s, vecs[i].d, rd, a, e, st, sa);
      checkOutput($sformatf("vec[%0d]", i),
                  {30'h0, a, e, (vecs[i].w && vecs[i].exp_ack) ? 32'h0 : rd},
                  {30'h0, vecs[i].exp_ack, vecs[i].exp_err,
                   (vecs[i].w && vecs[i].exp_ack) ? 32'h0 : vecs[i].exp_dat});
    end
    model_crc = 32'h0;

    // Randomized traffic with ignored address bits scrambled.
    for (int i = 0; i < 60; i++) begin
      int          pick;
      logic [31:0] rnd;
      rnd       = $urandom();
      adr_noise = $urandom();
      pick      = $urandom_range(0, 10);
      case (pick)
        0, 1, 2, 3: doOp($sformatf("rand[%0d] data_wr", i), 1'b1, 2'd1, 4'($urandom_range(0, 15)), rnd);
        4:  doOp($sformatf("rand[%0d] ctrl_wr", i), 1'b1, 2'd0, 4'hF, rnd);
        5:  doOp($sformatf("rand[%0d] ctrl_rd", i), 1'b0, 2'd0, 4'hF, rnd);
        6:  doOp($sformatf("rand[%0d] result_rd", i), 1'b0, 2'd2, 4'hF, rnd);
        7:  doOp($sformatf("rand[%0d] result_wr", i), 1'b1, 2'd2, 4'hF, rnd);
        8:  doOp($sformatf("rand[%0d] crc_rd", i), 1'b0, 2'd3, 4'hF, rnd);
        9:  doOp($sformatf("rand[%0d] crc_wr", i), 1'b1, 2'd3, 4'($urandom_range(0, 15)), rnd);
        default: doOp($sformatf("rand[%0d] data_rd", i), 1'b0, 2'd1, 4'hF, rnd);
      endcase
    end
    adr_noise = 32'h0;
    doOp("rand_final_crc", 1'b0, 2'd3, 4'hF, 32'h0);

    // Full-word busy window.
    doOp("busy_init", 1'b1, 2'd0, 4'hF, 32'h1);
    measure_busy(4'hF, 32'hFFFFFFFF, ones, head);
    checkOutput("busy_full_count", 64'(ones), 64'(4 * CPB));
    checkOutput("busy_full_edge", {62'h0, head}, 64'h2);

    // RESULT read issued one cycle after the DATA ack waits out the whole busy window.
    begin
      logic [33:0] x;
      logic [31:0] m;
      predict(1'b1, 2'd1, 4'hF, 32'hFFFFFFFF, x, m);
      applyStimulus(1'b1, 2'd1, 4'hF, 32'hFFFFFFFF, rd, a, e, st, sa);
      @(posedge clk); #1;
      predict(1'b0, 2'd2, 4'hF, 32'h0, x, m);
      applyStimulus(1'b0, 2'd2, 4'hF, 32'h0, rd, a, e, st, sa);
      checkOutput("stall_cycles", 64'(st), 64'(4 * CPB));
      checkOutput("stall_no_early_ack", {63'h0, sa}, 64'h0);
      checkOutput("stall_result", {30'h0, a, e, rd}, {30'h0, x});
    end

    // Lane skipping: only lane 1 enabled.
    doOp("skip_init", 1'b1, 2'd0, 4'hF, 32'h1);
    measure_busy(4'h2, 32'h00003100, ones, head);
    checkOutput("skip_busy_count", 64'(ones), 64'(CPB));
    checkOutput("skip_busy_edge", {62'h0, head}, 64'h2);
    applyStimulus(1'b0, 2'd2, 4'hF, 32'h0, rd, a, e, st, sa);
    checkOutput("skip_result", {32'h0, rd}, 64'h83DCEFB7);
    doOp("skip_result_model", 1'b0, 2'd2, 4'hF, 32'h0);

    // Request abandoned while stalled: no response, shifting still completes.
    begin
      logic [33:0] x;
      logic [31:0] m;
      predict(1'b1, 2'd1, 4'h3, 32'hA5C3_5A3C, x, m);
      applyStimulus(1'b1, 2'd1, 4'h3, 32'hA5C3_5A3C, rd, a, e, st, sa);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h8;
      repeat ((CPB == 8) ? 4 : 1) begin @(posedge clk); #1; end
      cyc = 1'b0; stb = 1'b0; adr = 32'h0;
      spur = ack | err;
      repeat (3) begin @(posedge clk); #1; spur = spur | ack | err; end
      checkOutput("drop_no_response", {63'h0, spur}, 64'h0);
      doOp("drop_result", 1'b0, 2'd2, 4'hF, 32'h0);
    end

    // Reset pulse at bit 10 of a full-word shift, with a CTRL read accepted in the same cycle.
    doOp("rst_seed", 1'b1, 2'd0, 4'hF, 32'h1);
    applyStimulus(1'b1, 2'd1, 4'hF, 32'h12345678, rd, a, e, st, sa);
    repeat (11) begin @(posedge clk); #1; end
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    spur = ack | err;
    @(posedge clk); #1;
    spur = spur | ack | err;
    checkOutput("rst_no_response", {63'h0, spur}, 64'h0);
    model_crc = INIT;
    doOp("rst_ctrl", 1'b0, 2'd0, 4'hF, 32'h0);
    applyStimulus(1'b0, 2'd0, 4'hF, 32'h0, rd, a, e, st, sa);
    checkOutput("rst_busy_clear", {32'h0, rd}, 64'h0);
    doOp("rst_crc", 1'b0, 2'd3, 4'hF, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
